// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM states and iteration sizing.
package muldiv_pkg;

    // One iteration per operand bit
    localparam int ITER  = 32;
    localparam int CNT_W = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Magnitude of a 32-bit operand; only signed operations strip the sign
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the datapath and the multiply/divide unit.
// master = issuing side (register file / pipeline), slave = muldiv_unit.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath (purely combinational).
// Multiply: acc = {partial, multiplier}; conditional add then shift right.
// Divide:   acc = {remainder, dividend/quotient}; restoring shift-subtract.
// The divide branch exists only when MULDIV_DIV_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [63:0] acc_in,
    input  logic [31:0] operand,
    input  logic        div_mode,
    output logic [63:0] acc_out
);

    logic [32:0] sum;

    // Carry out of the add becomes the top bit after the right shift
    assign sum = {1'b0, acc_in[63:32]} + {1'b0, (acc_in[0] ? operand : 32'd0)};

`ifdef MULDIV_DIV_EN
    logic [32:0] top;
    logic [31:0] diff;
    logic        ge;

    // Partial remainder with the next dividend bit shifted in
    assign top  = acc_in[63:31];
    assign ge   = (top >= {1'b0, operand});
    // When ge holds the difference is below the divisor, so 32 bits suffice
    assign diff = top[31:0] - operand;

    // Select the multiply or divide step
    always_comb begin
        acc_out = {sum, acc_in[31:1]};
        if (div_mode) begin
            acc_out = {(ge ? diff : top[31:0]), acc_in[30:0], ge};
        end
    end
`else
    logic unused_div_mode;
    assign unused_div_mode = div_mode;
    assign acc_out         = {sum, acc_in[31:1]};
`endif

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO registers.
// Operands are reduced to magnitudes at start, iterated for ITER cycles by
// muldiv_step, then sign-corrected in a single FIX cycle.
// Define MULDIV_DIV_EN to include DIV/DIVU; without it divide requests
// complete immediately and leave HI/LO untouched.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    op_t               op_reg;
    logic [63:0]       acc_reg;
    logic [63:0]       acc_step;
    logic [31:0]       operand_reg;
    logic              neg_q_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [31:0]       hi_reg;
    logic [31:0]       lo_reg;
`ifdef MULDIV_DIV_EN
    logic              neg_r_reg;
    logic [31:0]       dividend_reg;
`endif

    logic              op_signed;
    logic              op_is_div;
    logic              cur_is_div;
    logic [31:0]       abs_rs;
    logic [31:0]       abs_rt;
    logic [63:0]       prod_fix;
    logic [31:0]       hi_fix;
    logic [31:0]       lo_fix;

    assign op_signed  = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign op_is_div  = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
    assign cur_is_div = (op_reg == OP_DIV)  || (op_reg == OP_DIVU);
    assign abs_rs     = abs32(bus.rs_data, op_signed);
    assign abs_rt     = abs32(bus.rt_data, op_signed);

    muldiv_step u_step (
        .acc_in   (acc_reg),
        .operand  (operand_reg),
        .div_mode (cur_is_div),
        .acc_out  (acc_step)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN for ITER cycles -> FIX -> IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
`ifdef MULDIV_DIV_EN
                    state_next = RUN;
`else
                    state_next = op_is_div ? FIX : RUN;
`endif
                end
            end
            RUN: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Final sign correction and special cases, applied in the FIX cycle
    always_comb begin
        prod_fix = neg_q_reg ? (64'd0 - acc_reg) : acc_reg;
        hi_fix   = prod_fix[63:32];
        lo_fix   = prod_fix[31:0];
`ifdef MULDIV_DIV_EN
        if (cur_is_div) begin
            if (operand_reg == 32'd0) begin
                // Divide by zero: all-ones quotient, dividend passed through raw
                lo_fix = 32'hFFFF_FFFF;
                hi_fix = dividend_reg;
            end else begin
                lo_fix = neg_q_reg ? (32'd0 - acc_reg[31:0])  : acc_reg[31:0];
                hi_fix = neg_r_reg ? (32'd0 - acc_reg[63:32]) : acc_reg[63:32];
            end
        end
`else
        if (cur_is_div) begin
            hi_fix = hi_reg;
            lo_fix = lo_reg;
        end
`endif
    end

    // Datapath: operand capture, iteration, result write and HI/LO moves
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg      <= '0;
            op_reg       <= OP_MULT;
            acc_reg      <= '0;
            operand_reg  <= '0;
            neg_q_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
`ifdef MULDIV_DIV_EN
            neg_r_reg    <= 1'b0;
            dividend_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        op_reg      <= op_t'(bus.op);
                        // Multiply iterates over rt bits; divide shifts out rs bits
                        operand_reg <= op_is_div ? abs_rt : abs_rs;
                        acc_reg     <= {32'd0, (op_is_div ? abs_rs : abs_rt)};
                        neg_q_reg   <= op_signed & (bus.rs_data[31] ^ bus.rt_data[31]);
`ifdef MULDIV_DIV_EN
                        neg_r_reg    <= op_signed & bus.rs_data[31];
                        dividend_reg <= bus.rs_data;
`endif
                        cnt_reg     <= CNT_W'(ITER);
                        busy_reg    <= 1'b1;
                    end else begin
                        // Moves only land when no operation is being started
                        if (bus.mthi) hi_reg <= bus.rs_data;
                        if (bus.mtlo) lo_reg <= bus.rs_data;
                    end
                end
                RUN: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
                FIX: begin
                    hi_reg   <= hi_fix;
                    lo_reg   <= lo_fix;
                    cnt_reg  <= '0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
                default: begin
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Expected HI/LO/latency come from a
// behavioural model and are queued at issue time, then popped on done.
module tb_muldiv_unit;

    logic clock;
    logic reset;

    muldiv_if bus();

    muldiv_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    always #5 clock = ~clock;

    // Drive one operation request and queue its predicted result
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t             e;
        logic [63:0]      p;
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        e.lat = 33;
        e.hi  = model_hi;
        e.lo  = model_lo;
        case (op)
            2'd0: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                end else if (op == 2'd2) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000;
                        e.hi = 32'd0;
                    end else begin
                        sa   = a;
                        sbv  = b;
                        e.lo = sa / sbv;
                        e.hi = sa % sbv;
                    end
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
`else
                sa    = 32'sd0;
                sbv   = 32'sd0;
                e.lat = 1;
`endif
            end
        endcase
        model_hi = e.hi;
        model_lo = e.lo;
        sb.push_back(e);
        @(negedge clock);
        bus.op      = op;
        bus.rs_data = a;
        bus.rt_data = b;
        bus.start   = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    // Wait for done and compare against the oldest queued expectation
    task automatic wait_result(input string name, input int elapsed);
        exp_t e;
        int   cyc;
        int   busy_cnt;
        bit   got;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e        = sb.pop_front();
            cyc      = elapsed;
            busy_cnt = elapsed + (bus.busy ? 1 : 0);
            got      = 1'b0;
            while (!got && cyc < 200) begin
                @(posedge clock);
                #1;
                cyc++;
                if (bus.done) got = 1'b1;
                else if (bus.busy) busy_cnt++;
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL %s_timeout: no done within %0d cycles", name, cyc);
            end else begin
                $display("txn %s: hi=%08h lo=%08h cycles=%0d", name, bus.hi, bus.lo, cyc);
                n_checks++;
                if (cyc !== e.lat) begin
                    n_fail++;
                    $display("FAIL %s_latency: got %0d want %0d", name, cyc, e.lat);
                end
                n_checks++;
                if (busy_cnt !== e.lat) begin
                    n_fail++;
                    $display("FAIL %s_busy: got %0d want %0d", name, busy_cnt, e.lat);
                end
                n_checks++;
                if (bus.hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL %s_hi: got %08h want %08h", name, bus.hi, e.hi);
                end
                n_checks++;
                if (bus.lo !== e.lo) begin
                    n_fail++;
                    $display("FAIL %s_lo: got %08h want %08h", name, bus.lo, e.lo);
                end
            end
        end
    endtask

    task automatic do_move(input logic h, input logic l, input logic [31:0] v);
        @(negedge clock);
        bus.mthi    = h;
        bus.mtlo    = l;
        bus.rs_data = v;
        @(posedge clock);
        #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        if (h) model_hi = v;
        if (l) model_lo = v;
    endtask

    task automatic check_hilo(input string name);
        n_checks++;
        if (bus.hi !== model_hi || bus.lo !== model_lo) begin
            n_fail++;
            $display("FAIL %s: got hi=%08h lo=%08h want hi=%08h lo=%08h",
                     name, bus.hi, bus.lo, model_hi, model_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b hi=%08h lo=%08h want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_moves();
        do_move(1'b1, 1'b1, 32'hCAFE_F00D);
        check_hilo("move_both");
        do_move(1'b1, 1'b0, 32'h1234_5678);
        check_hilo("move_hi");
        do_move(1'b0, 1'b1, 32'h9ABC_DEF0);
        check_hilo("move_lo");
    endtask

    task automatic test_mult();
        issue(2'd0, 32'd7, 32'hFFFF_FFFD);
        wait_result("mult_7x-3", 0);
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got %b want 0", bus.done);
        end
        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result("multu_max", 0);
        issue(2'd0, 32'h8000_0000, 32'h8000_0000);
        wait_result("mult_minxmin", 0);
    endtask

    task automatic test_div();
`ifdef MULDIV_DIV_EN
        issue(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_result("div_-7/2", 0);
        issue(2'd3, 32'd100, 32'd0);
        wait_result("divu_by0", 0);
        issue(2'd2, 32'hFFFF_FFFB, 32'd0);
        wait_result("div_neg_by0", 0);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_result("div_overflow", 0);
        issue(2'd3, 32'hFFFF_FFFF, 32'd7);
        wait_result("divu_big", 0);
`else
        do_move(1'b1, 1'b1, 32'h1111_1111);
        do_move(1'b0, 1'b1, 32'h2222_2222);
        issue(2'd2, 32'd100, 32'd3);
        wait_result("div_disabled", 0);
        issue(2'd3, 32'd7, 32'd0);
        wait_result("divu_disabled", 0);
        issue(2'd1, 32'd5, 32'd9);
        wait_result("mult_after_div", 0);
`endif
    endtask

    task automatic test_hold();
        do_move(1'b1, 1'b1, 32'hDEAD_0001);
        do_move(1'b0, 1'b1, 32'hBEEF_0002);
        issue(2'd1, 32'h0001_0000, 32'h0001_0000);
        repeat (10) @(posedge clock);
        #1;
        n_checks++;
        if (bus.hi !== 32'hDEAD_0001 || bus.lo !== 32'hBEEF_0002) begin
            n_fail++;
            $display("FAIL hold_during_run: got hi=%08h lo=%08h want DEAD0001 BEEF0002", bus.hi, bus.lo);
        end
        wait_result("hold_multu", 10);
    endtask

    task automatic test_ignore_busy();
        issue(2'd0, 32'd3, 32'd4);
        repeat (4) @(posedge clock);
        @(negedge clock);
        bus.op      = 2'd3;
        bus.rs_data = 32'h0000_AAAA;
        bus.rt_data = 32'd3;
        bus.start   = 1'b1;
        bus.mthi    = 1'b1;
        bus.mtlo    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        n_checks++;
        if (bus.hi === 32'h0000_AAAA || bus.lo === 32'h0000_AAAA) begin
            n_fail++;
            $display("FAIL move_while_busy: got hi=%08h lo=%08h want neither AAAA", bus.hi, bus.lo);
        end
        wait_result("ignore_busy_3x4", 5);
    endtask

    task automatic test_start_vs_move();
        do_move(1'b1, 1'b0, 32'h0000_1234);
        issue(2'd0, 32'd5, 32'd6);
        // issue() leaves mthi low; re-run with mthi asserted alongside start
        wait_result("pre_startmove", 0);
        do_move(1'b1, 1'b0, 32'h0000_1234);
        sb.push_back('{hi: 32'd0, lo: 32'd30, lat: 33});
        @(negedge clock);
        bus.op      = 2'd0;
        bus.rs_data = 32'd5;
        bus.rt_data = 32'd6;
        bus.start   = 1'b1;
        bus.mthi    = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        n_checks++;
        if (bus.hi !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL start_beats_move: got hi=%08h want 00001234", bus.hi);
        end
        model_hi = 32'd0;
        model_lo = 32'd30;
        wait_result("start_with_mthi", 0);
    endtask

    task automatic test_start_in_fix();
        exp_t e;
        issue(2'd0, 32'd6, 32'd7);
        e = sb.pop_front();
        repeat (32) @(posedge clock);
        @(negedge clock);
        bus.op      = 2'd1;
        bus.rs_data = 32'd9;
        bus.rt_data = 32'd9;
        bus.start   = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.lo !== e.lo || bus.hi !== e.hi) begin
            n_fail++;
            $display("FAIL fix_edge: got done=%b busy=%b hi=%08h lo=%08h want 1 0 %08h %08h",
                     bus.done, bus.busy, bus.hi, bus.lo, e.hi, e.lo);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_in_fix: got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        issue(2'd1, 32'd1000, 32'd1000);
        wait_result("b2b_first", 0);
        issue(2'd0, 32'hFFFF_FFFF, 32'd2);
        wait_result("b2b_second", 0);
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 4) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
            issue(op, a, b);
            wait_result($sformatf("rand%0d_op%0d", i, op), 0);
        end
    endtask

    task automatic test_reset_mid();
        do_move(1'b1, 1'b1, 32'h0000_0055);
        issue(2'd0, 32'd11, 32'd13);
        repeat (10) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b hi=%08h lo=%08h want 0 0 0 0",
                     bus.busy, bus.done, bus.hi, bus.lo);
        end
        @(negedge clock);
        reset = 1'b0;
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        issue(2'd0, 32'd11, 32'd13);
        wait_result("after_reset", 0);
    endtask

    // Global guard against a stuck simulation
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clock       = 1'b0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.mthi    = 1'b0;
        bus.mtlo    = 1'b0;
        test_reset();
        test_moves();
        test_mult();
        test_div();
        test_hold();
        test_ignore_busy();
        test_start_vs_move();
        test_start_in_fix();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
